music_box_state_controller: RTL and testbench

- Initiator side of the state-select/stateComplete handshake used by all MusicBoxState_* user-interface modules.
- Accepts state requests from the button/UI front end and drives the shared currentState bus.
- Waits for the selected module to raise stateComplete, then returns currentState to DoNothing (0).
- Adds a watchdog timeout and an inter-state holdoff, so a state module running on the 1 kHz clock always sees currentState leave its value before it can be re-entered.

---
 rtl/music_box_pkg.sv | 13 +
 rtl/music_box_state_controller_if.sv | 22 ++
 rtl/music_box_cycle_timer.sv | 25 ++
 rtl/music_box_state_controller.sv | 103 ++++++++++
 tb/tb_music_box_state_controller.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/music_box_pkg.sv
// Shared types and state codes for the MusicBoxState_* handshake.
package music_box_pkg;
  typedef logic [4:0] music_box_state_t;

  localparam music_box_state_t STATE_DO_NOTHING = 5'd0;
  localparam music_box_state_t STATE_PLAY_SONG0 = 5'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    RELEASE = 2'd2
  } ctrl_fsm_t;
endpackage

// File: rtl/music_box_state_controller_if.sv
// Request/state-bus signals between the UI front end, the controller and the state modules.
interface music_box_state_controller_if;
  import music_box_pkg::*;

  logic             requestValid;
  music_box_state_t requestState;
  logic             stateComplete;
  music_box_state_t currentState;
  logic             busy;
  logic             timeoutPulse;
  logic [31:0]      debugString;

  modport master (
    input  requestValid, requestState, stateComplete,
    output currentState, busy, timeoutPulse, debugString
  );

  modport slave (
    output requestValid, requestState, stateComplete,
    input  currentState, busy, timeoutPulse, debugString
  );
endinterface

// File: rtl/music_box_cycle_timer.sv
// Clearable saturating up-counter; reached is high once the count is at or past term.
module music_box_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [WIDTH-1:0] term,
  output logic             reached
);
  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)              cnt_d = '0;
    else if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign reached = (cnt_q >= term);
endmodule

// File: rtl/music_box_state_controller.sv
// Drives the shared currentState bus: IDLE -> ACTIVE until stateComplete/watchdog/abort,
// then a RELEASE holdoff so slow-clocked state modules always see the bus return to 0.
module music_box_state_controller
  import music_box_pkg::*;
#(
  parameter int NUM_STATES     = 8,
  parameter int TIMEOUT_CYCLES = 500000000,
  parameter int HOLDOFF_CYCLES = 50000
) (
  input  logic clock_50Mhz,
  input  logic reset,
  music_box_state_controller_if.master bus
);
  localparam int MAX_CYC = (TIMEOUT_CYCLES > HOLDOFF_CYCLES) ? TIMEOUT_CYCLES : HOLDOFF_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0]    TO_TERM  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    HO_TERM  = CW'(HOLDOFF_CYCLES - 1);
  localparam music_box_state_t MAX_CODE = music_box_state_t'(NUM_STATES - 1);

  ctrl_fsm_t        state_q, state_d;
  music_box_state_t code_q, code_d;
  music_box_state_t cur_q, cur_d;
  logic             busy_q, busy_d;
  logic             pulse_q, pulse_d;
  logic [15:0]      cmpl_q, cmpl_d;
  logic [7:0]       to_q, to_d;
  logic             tmr_clr, tmr_reached;
  logic [CW-1:0]    tmr_term;

  // One timer serves both the watchdog (ACTIVE) and the holdoff (RELEASE).
  assign tmr_term = (state_q == ACTIVE) ? TO_TERM : HO_TERM;

  music_box_cycle_timer #(.WIDTH(CW)) u_timer (
    .clk     (clock_50Mhz),
    .rst     (reset),
    .clr     (tmr_clr),
    .term    (tmr_term),
    .reached (tmr_reached)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    pulse_d = 1'b0;
    cmpl_d  = cmpl_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (bus.requestValid && bus.requestState != STATE_DO_NOTHING &&
            bus.requestState <= MAX_CODE && !bus.stateComplete) begin
          state_d = ACTIVE;
          code_d  = bus.requestState;
        end
      end
      ACTIVE: begin
        if (bus.stateComplete) begin
          state_d = RELEASE;
          cmpl_d  = cmpl_q + 16'd1;
        end else if (tmr_reached) begin
          state_d = RELEASE;
          pulse_d = 1'b1;
          to_d    = to_q + 8'd1;
        end else if (bus.requestValid && bus.requestState == STATE_DO_NOTHING) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (tmr_reached && !bus.stateComplete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Timer restarts on every phase change and is held at 0 while idle.
    tmr_clr = (state_d != state_q) || (state_q == IDLE);
    cur_d   = (state_d == ACTIVE) ? code_d : STATE_DO_NOTHING;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= STATE_DO_NOTHING;
      cur_q   <= STATE_DO_NOTHING;
      busy_q  <= 1'b0;
      pulse_q <= 1'b0;
      cmpl_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cur_q   <= cur_d;
      busy_q  <= busy_d;
      pulse_q <= pulse_d;
      cmpl_q  <= cmpl_d;
      to_q    <= to_d;
    end
  end

  assign bus.currentState = cur_q;
  assign bus.busy         = busy_q;
  assign bus.timeoutPulse = pulse_q;
  assign bus.debugString  = {cmpl_q, to_q, state_q, 1'b0, cur_q};
endmodule

// File: tb/tb_music_box_state_controller.sv
// Directed handshake scenarios followed by random traffic, checked against a phase/age model.
module tb_music_box_state_controller;
  localparam int NS = 8, TO = 100, HO = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  music_box_state_controller_if bus();

  music_box_state_controller #(
    .NUM_STATES(NS), .TIMEOUT_CYCLES(TO), .HOLDOFF_CYCLES(HO)
  ) dut (
    .clock_50Mhz (clk),
    .reset       (rst),
    .bus         (bus)
  );

  always #10 clk = ~clk;

  // Model: phase 0=idle 1=running 2=cool-down; age = cycles already spent in the phase.
  int          m_phase = 0, m_age = 0, m_code = 0;
  logic [15:0] m_cmpl = 0;
  logic [7:0]  m_to = 0;
  logic        m_pulse = 0;

  task automatic model_step(input logic r, input logic rv, input int rs, input logic sc);
    m_pulse = 1'b0;
    if (r) begin
      m_phase = 0; m_age = 0; m_code = 0; m_cmpl = 0; m_to = 0;
    end else if (m_phase == 0) begin
      if (rv && rs >= 1 && rs < NS && !sc) begin m_phase = 1; m_age = 0; m_code = rs; end
    end else if (m_phase == 1) begin
      if (sc) begin m_cmpl++; m_phase = 2; m_age = 0; end
      else if (m_age == TO - 1) begin m_to++; m_pulse = 1'b1; m_phase = 2; m_age = 0; end
      else if (rv && rs == 0) begin m_phase = 2; m_age = 0; end
      else m_age++;
    end else begin
      if (m_age >= HO - 1 && !sc) begin m_phase = 0; m_age = 0; end
      else m_age++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare all outputs after it.
  task automatic cyc(input logic rv, input int rs, input logic sc, input logic r = 1'b0);
    logic [4:0]  ecur;
    logic [31:0] edbg;
    rst = r;
    bus.requestValid  = rv;
    bus.requestState  = 5'(rs);
    bus.stateComplete = sc;
    @(posedge clk);
    model_step(r, rv, rs, sc);
    #1;
    ecur = (m_phase == 1) ? 5'(m_code) : 5'd0;
    edbg = {m_cmpl, m_to, 2'(m_phase), 1'b0, ecur};
    chk("currentState", 32'(bus.currentState), 32'(ecur));
    chk("busy", 32'(bus.busy), 32'(m_phase != 0));
    chk("timeoutPulse", 32'(bus.timeoutPulse), 32'(m_pulse));
    chk("debugString", bus.debugString, edbg);
  endtask

  task automatic idle_n(input int n, input logic sc = 1'b0);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, sc);
  endtask

  initial begin
    int sc_run;
    bus.requestValid = 1'b0; bus.requestState = '0; bus.stateComplete = 1'b0;

    // Reset state
    cyc(0, 0, 0, 1'b1); cyc(0, 0, 0, 1'b1);
    chk("reset_dbg", bus.debugString, 32'h0);
    idle_n(2);

    // Normal completion
    cyc(1, 1, 0);
    chk("norm_cur", 32'(bus.currentState), 32'd1);
    idle_n(29);
    cyc(0, 0, 1);
    chk("norm_cur_drop", 32'(bus.currentState), 32'd0);
    idle_n(19, 1'b1);
    idle_n(12);
    chk("norm_idle", bus.debugString, 32'h0001_0000);

    // Watchdog timeout
    cyc(1, 3, 0);
    idle_n(99);
    chk("to_cur_held", 32'(bus.currentState), 32'd3);
    cyc(0, 0, 0);
    chk("to_pulse", 32'(bus.timeoutPulse), 32'd1);
    chk("to_count", 32'(bus.debugString[15:8]), 32'd1);
    cyc(0, 0, 0);
    chk("to_pulse_once", 32'(bus.timeoutPulse), 32'd0);
    idle_n(12);

    // Completion and timeout together: completion wins
    cyc(1, 5, 0);
    idle_n(99);
    cyc(0, 0, 1);
    chk("both_nopulse", 32'(bus.timeoutPulse), 32'd0);
    chk("both_counts", 32'(bus.debugString[31:8]), 32'h0002_01);
    idle_n(12);

    // Ignored requests
    cyc(1, 0, 0); cyc(1, 9, 0); cyc(1, 8, 0);
    chk("ign_idle", 32'(bus.currentState), 32'd0);
    cyc(1, 2, 1);
    chk("ign_sc_high", 32'(bus.currentState), 32'd0);
    cyc(1, 1, 0);
    cyc(1, 2, 0);
    chk("ign_active", 32'(bus.currentState), 32'd1);

    // Abort then holdoff
    idle_n(3);
    cyc(1, 0, 0);
    chk("abort", 32'(bus.currentState), 32'd0);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("holdoff_drop", 32'(bus.currentState), 32'd0);
    cyc(1, 2, 0);
    idle_n(10);
    cyc(1, 1, 0);
    chk("after_holdoff", 32'(bus.currentState), 32'd1);
    chk("abort_counts", 32'(bus.debugString[31:8]), 32'h0002_01);
    cyc(0, 0, 1);
    idle_n(12);

    // Reset mid-ACTIVE
    cyc(1, 4, 0);
    idle_n(5);
    cyc(0, 0, 0, 1'b1);
    chk("rst_mid", bus.debugString, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'd0);

    // Random traffic
    sc_run = 0;
    for (int i = 0; i < 3000; i++) begin
      logic sc;
      if (sc_run > 0) sc_run--;
      else if ($urandom_range(0, 39) == 0) sc_run = int'($urandom_range(1, 15));
      sc = (sc_run > 0);
      cyc(($urandom_range(0, 5) == 0), int'($urandom_range(0, 10)), sc,
          ($urandom_range(0, 399) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
